// File: rtl/subtree_sched_pkg.sv
// Shared types and helpers for the subtree round-robin scheduler.
package subtree_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_GAP
  } sched_state_e;

  function automatic int IDX_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first set request searching upward from last+1, wrapping at N_CHILD.
module rr_pick
  import subtree_sched_pkg::*;
#(
  parameter int N_CHILD = 5,
  parameter int IW      = IDX_W(N_CHILD)
) (
  input  logic [N_CHILD-1:0] i_req,
  input  logic [IW-1:0]      i_last,
  output logic [IW-1:0]      o_pick_idx,
  output logic               o_pick_vld
);

  localparam logic [IW:0] NC = (IW+1)'(N_CHILD);

  logic [IW-1:0]        w_start;
  logic [2*N_CHILD-1:0] w_dbl;
  logic [N_CHILD-1:0]   w_rot;
  logic [IW-1:0]        w_off;
  logic                 w_found;
  logic [IW:0]          w_sum;

  assign w_start = (i_last == IW'(N_CHILD-1)) ? '0 : i_last + 1'b1;
  // Doubling the vector turns the circular search into a plain shift.
  assign w_dbl   = {i_req, i_req};
  assign w_rot   = N_CHILD'(w_dbl >> w_start);

  always_comb begin
    w_off   = '0;
    w_found = 1'b0;
    for (int k = 0; k < N_CHILD; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_off   = IW'(k);
      end
    end
  end

  assign w_sum      = {1'b0, w_start} + {1'b0, w_off};
  assign o_pick_idx = (w_sum >= NC) ? IW'(w_sum - NC) : w_sum[IW-1:0];
  assign o_pick_vld = |i_req;

endmodule

// File: rtl/subtree_rr_scheduler.sv
// Time-shares one exclusive resource among the children of a subtree node,
// holding each grant until the child signals done or the hold timer expires.
module subtree_rr_scheduler
  import subtree_sched_pkg::*;
#(
  parameter int N_CHILD  = 5,
  parameter int MAX_HOLD = 64,
  parameter int GAP      = 1,
  parameter int IW       = IDX_W(N_CHILD)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N_CHILD-1:0] i_req,
  input  logic [N_CHILD-1:0] i_done,
  input  logic               i_clr_err,
  output logic [N_CHILD-1:0] o_grant,
  output logic               o_grant_vld,
  output logic [IW-1:0]      o_grant_idx,
  output logic               o_timeout,
  output logic               o_err_sticky,
  output logic [IW-1:0]      o_err_idx
);

  localparam int HW = IDX_W(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD-1);
  localparam logic [1:0]    GAP_LAST  = 2'(GAP-1);
  localparam sched_state_e  REL_STATE = (GAP == 0) ? S_IDLE : S_GAP;

  sched_state_e       r_state, w_state_n;
  logic [HW-1:0]      r_hold_cnt, w_hold_n;
  logic [1:0]         r_gap_cnt, w_gap_n;
  logic [IW-1:0]      r_last, w_last_n;
  logic [N_CHILD-1:0] r_grant, w_grant_n;
  logic [IW-1:0]      r_grant_idx, w_grant_idx_n;
  logic               r_timeout, w_timeout_n;
  logic               r_err_sticky, w_err_sticky_n;
  logic [IW-1:0]      r_err_idx, w_err_idx_n;
  logic [IW-1:0]      w_pick_idx;
  logic               w_pick_vld;
  logic               w_done_g;

  rr_pick #(.N_CHILD(N_CHILD), .IW(IW)) u_pick (
    .i_req      (i_req),
    .i_last     (r_last),
    .o_pick_idx (w_pick_idx),
    .o_pick_vld (w_pick_vld)
  );

  assign w_done_g = i_done[r_grant_idx];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_hold_cnt   <= '0;
      r_gap_cnt    <= '0;
      r_last       <= IW'(N_CHILD-1);
      r_grant      <= '0;
      r_grant_idx  <= '0;
      r_timeout    <= 1'b0;
      r_err_sticky <= 1'b0;
      r_err_idx    <= '0;
    end else begin
      r_state      <= w_state_n;
      r_hold_cnt   <= w_hold_n;
      r_gap_cnt    <= w_gap_n;
      r_last       <= w_last_n;
      r_grant      <= w_grant_n;
      r_grant_idx  <= w_grant_idx_n;
      r_timeout    <= w_timeout_n;
      r_err_sticky <= w_err_sticky_n;
      r_err_idx    <= w_err_idx_n;
    end
  end

  always_comb begin
    w_state_n      = r_state;
    w_hold_n       = r_hold_cnt;
    w_gap_n        = r_gap_cnt;
    w_last_n       = r_last;
    w_grant_n      = r_grant;
    w_grant_idx_n  = r_grant_idx;
    w_timeout_n    = 1'b0;
    w_err_sticky_n = r_err_sticky & ~i_clr_err;
    w_err_idx_n    = r_err_idx;
    case (r_state)
      S_IDLE: begin
        if (w_pick_vld) begin
          w_grant_n             = '0;
          w_grant_n[w_pick_idx] = 1'b1;
          w_grant_idx_n         = w_pick_idx;
          w_last_n              = w_pick_idx;
          w_hold_n              = '0;
          w_state_n             = S_HOLD;
        end
      end
      S_HOLD: begin
        // done takes priority so a completion on the last hold cycle is not flagged
        if (w_done_g) begin
          w_grant_n = '0;
          w_gap_n   = '0;
          w_state_n = REL_STATE;
        end else if (r_hold_cnt == HOLD_LAST) begin
          w_grant_n      = '0;
          w_gap_n        = '0;
          w_state_n      = REL_STATE;
          w_timeout_n    = 1'b1;
          w_err_sticky_n = 1'b1;
          w_err_idx_n    = r_grant_idx;
        end else begin
          w_hold_n = r_hold_cnt + 1'b1;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == GAP_LAST) w_state_n = S_IDLE;
        else                       w_gap_n   = r_gap_cnt + 1'b1;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  assign o_grant      = r_grant;
  assign o_grant_vld  = |r_grant;
  assign o_grant_idx  = r_grant_idx;
  assign o_timeout    = r_timeout;
  assign o_err_sticky = r_err_sticky;
  assign o_err_idx    = r_err_idx;

endmodule

// File: tb/tb_subtree_rr_scheduler.sv
// Scoreboard bench for subtree_rr_scheduler with default parameters.
module tb_subtree_rr_scheduler;

  localparam int N        = 5;
  localparam int MAX_HOLD = 64;
  localparam int ZEROS    = 2;  // GAP=1 cycle plus the IDLE sampling cycle

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] done;
  logic         clr_err;
  logic [N-1:0] grant;
  logic         grant_vld;
  logic [2:0]   grant_idx;
  logic         timeout;
  logic         err_sticky;
  logic [2:0]   err_idx;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  subtree_rr_scheduler dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req        (req),
    .i_done       (done),
    .i_clr_err    (clr_err),
    .o_grant      (grant),
    .o_grant_vld  (grant_vld),
    .o_grant_idx  (grant_idx),
    .o_timeout    (timeout),
    .o_err_sticky (err_sticky),
    .o_err_idx    (err_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic pulse_done(input logic [N-1:0] m);
    done = m;
    step();
    done = '0;
  endtask

  // Steps until a grant is visible; idx=-1 if the budget runs out.
  task automatic wait_grant(input int budget, output int idx, output int zeros);
    idx   = -1;
    zeros = 0;
    for (int n = 0; n < budget; n++) begin
      if (grant_vld) begin
        idx = int'(grant_idx);
        break;
      end
      zeros++;
      step();
    end
  endtask

  task automatic sb_check(input string tag, input int idx);
    int e;
    logic [N-1:0] m;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: grant %0d observed with nothing expected", tag, idx);
      return;
    end
    e = exp_q.pop_front();
    if (idx !== e) begin
      errors++;
      $display("FAIL %s: grant_idx %0d, expected %0d", tag, idx, e);
    end
    m = '0;
    if (e >= 0) m[e] = 1'b1;
    checks++;
    if (grant !== m) begin
      errors++;
      $display("FAIL %s_onehot: grant %b, expected %b", tag, grant, m);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; done = '0; clr_err = 1'b0;
    step(); step();
    checks++;
    if ({grant, grant_vld, grant_idx, timeout, err_sticky, err_idx} !== '0) begin
      errors++;
      $display("FAIL reset: grant=%b vld=%b idx=%0d to=%b err=%b eidx=%0d, expected all zero",
               grant, grant_vld, grant_idx, timeout, err_sticky, err_idx);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int idx, z;
    req = 5'b00100;
    exp_q.push_back(2);
    step();
    checks++;
    if (grant_vld !== 1'b1) begin
      errors++;
      $display("FAIL single_latency: grant_vld %b, expected 1 one cycle after req", grant_vld);
    end
    wait_grant(4, idx, z);
    sb_check("single_grant", idx);
    req = '0;
    pulse_done(5'b00100);
    checks++;
    if (grant !== 5'b00000) begin
      errors++;
      $display("FAIL single_release: grant %b, expected 00000", grant);
    end
  endtask

  task automatic test_round_robin();
    int idx, z;
    do_reset();
    req = 5'b11111;
    for (int i = 0; i < 6; i++) exp_q.push_back(i % N);
    for (int i = 0; i < 6; i++) begin
      wait_grant(10, idx, z);
      sb_check("rr_order", idx);
      if (i > 0) begin
        checks++;
        if (z !== ZEROS) begin
          errors++;
          $display("FAIL rr_gap: %0d idle cycles between grants, expected %0d", z, ZEROS);
        end
      end
      step(); step();
      pulse_done(grant);
    end
    req = '0;
  endtask

  task automatic test_timeout();
    int idx, z, held;
    do_reset();
    req = 5'b01000;
    exp_q.push_back(3);
    wait_grant(5, idx, z);
    sb_check("to_grant", idx);
    held = 0;
    for (int n = 0; n < 100 && grant_vld; n++) begin
      held++;
      step();
    end
    req = '0;
    checks++;
    if (held !== MAX_HOLD) begin
      errors++;
      $display("FAIL to_hold: held %0d cycles, expected %0d", held, MAX_HOLD);
    end
    checks++;
    if ({timeout, err_sticky, err_idx} !== {1'b1, 1'b1, 3'd3}) begin
      errors++;
      $display("FAIL to_flags: timeout=%b err=%b eidx=%0d, expected 1 1 3", timeout, err_sticky, err_idx);
    end
    step();
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL to_pulse: timeout %b, expected 0 on second cycle", timeout);
    end
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    checks++;
    if (err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL to_clr: err_sticky %b, expected 0", err_sticky);
    end
  endtask

  task automatic test_done_filter();
    int idx, z;
    do_reset();
    req = 5'b00010;
    exp_q.push_back(1);
    wait_grant(5, idx, z);
    sb_check("filt_grant", idx);
    req = '0;
    pulse_done(5'b10001);
    checks++;
    if (grant !== 5'b00010) begin
      errors++;
      $display("FAIL filt_foreign_done: grant %b, expected 00010", grant);
    end
    req = 5'b00011;
    step();
    checks++;
    if (grant !== 5'b00010) begin
      errors++;
      $display("FAIL filt_req_drop: grant %b, expected 00010", grant);
    end
    pulse_done(5'b00010);
    checks++;
    if (grant !== 5'b00000) begin
      errors++;
      $display("FAIL filt_release: grant %b, expected 00000", grant);
    end
    exp_q.push_back(0);
    wait_grant(6, idx, z);
    sb_check("filt_fair", idx);
    req = '0;
    pulse_done(grant);
  endtask

  task automatic test_rst_mid_hold();
    int idx, z;
    do_reset();
    req = 5'b11111;
    for (int i = 0; i < 3; i++) exp_q.push_back(i);
    for (int i = 0; i < 3; i++) begin
      wait_grant(10, idx, z);
      sb_check("rst_pre", idx);
      if (i < 2) pulse_done(grant);
    end
    rst = 1'b1;
    step();
    checks++;
    if (grant !== 5'b00000) begin
      errors++;
      $display("FAIL rst_drop: grant %b, expected 00000", grant);
    end
    rst = 1'b0;
    exp_q.push_back(0);
    wait_grant(5, idx, z);
    sb_check("rst_restart", idx);
    req = '0;
    pulse_done(grant);
  endtask

  task automatic test_back_to_back();
    int idx, z;
    do_reset();
    req  = 5'b10000;
    done = 5'b10000;
    for (int i = 0; i < 3; i++) exp_q.push_back(4);
    for (int i = 0; i < 3; i++) begin
      wait_grant(8, idx, z);
      sb_check("b2b_grant", idx);
      if (i > 0) begin
        checks++;
        if (z !== ZEROS) begin
          errors++;
          $display("FAIL b2b_gap: %0d idle cycles, expected %0d", z, ZEROS);
        end
      end
      step();
    end
    req  = '0;
    done = '0;
    checks++;
    if (err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL b2b_err: err_sticky %b, expected 0", err_sticky);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_done_filter();
    test_rst_mid_hold();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected grants never seen", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
